// File: rtl/c2h_gather_if.sv
// AXI4-Stream link carrying the framed C2H packet toward the XDMA channel.
interface c2h_gather_if #(
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0]      tdata;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic [BYTE_BIT_ENABLE-1:0] tkeep;

  modport master (output tdata, tvalid, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/c2h_gather.sv
// Drains the per-column result FIFOs in column order and frames them as one
// AXI4-Stream packet: a summary header beat followed by every result beat.
module c2h_gather #(
  parameter int DATA_WIDTH      = 128,
  parameter int BYTE_BIT_ENABLE = DATA_WIDTH/8,
  parameter int COL_MAX_SIZE    = 4
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic                               start,
  input  logic [16*COL_MAX_SIZE-1:0]         result_rows,
  input  logic [DATA_WIDTH*COL_MAX_SIZE-1:0] result_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            result_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            result_fifo_rd_en,
  c2h_gather_if.master                       m_axis_c2h,
  output logic                               gather_done
);
  localparam int COL_W = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, STREAM, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]                row_cnt [COL_MAX_SIZE];
  logic [31:0]                total;
  logic [31:0]                remaining;
  logic [COL_W-1:0]           col_sel;
  logic [DATA_WIDTH-1:0]      tdata;
  logic                       tvalid;
  logic                       tlast;
  logic [BYTE_BIT_ENABLE-1:0] tkeep;

  logic [31:0]           start_total;
  logic [COL_W-1:0]      start_col;
  logic                  start_found;
  logic [COL_W-1:0]      next_col;
  logic                  next_found;
  logic [DATA_WIDTH-1:0] header;
  logic                  can_load;
  logic                  pop;
  logic                  load_hdr;
  logic                  last_hs;

  // Packet size and first populated column from the rows presented with start.
  always_comb begin
    start_total = '0;
    start_col   = '0;
    start_found = 1'b0;
    for (int unsigned i = 0; i < COL_MAX_SIZE; i++) begin
      start_total = start_total + 32'(result_rows[16*i +: 16]);
      if (!start_found && (result_rows[16*i +: 16] != '0)) begin
        start_col   = COL_W'(i);
        start_found = 1'b1;
      end
    end
  end

  // Next populated column above the current one; empty columns are skipped.
  always_comb begin
    next_col   = col_sel;
    next_found = 1'b0;
    for (int unsigned i = 0; i < COL_MAX_SIZE; i++) begin
      if (!next_found && (COL_W'(i) > col_sel) && (row_cnt[i] != '0)) begin
        next_col   = COL_W'(i);
        next_found = 1'b1;
      end
    end
  end

  // Header beat: per-column row counts, packet total and a fixed tag.
  always_comb begin
    header         = '0;
    header[31:0]   = 32'h0000_C2A0;
    header[63:32]  = total;
    for (int unsigned i = 0; i < COL_MAX_SIZE; i++) begin
      if (i < 4) header[64+16*i +: 16] = row_cnt[i];
    end
  end

  // State register.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER:  if (can_load) state_nxt = (total == '0) ? DONE : STREAM;
      STREAM:  if (pop && (remaining == 32'd1)) state_nxt = DONE;
      DONE:    if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake-derived controls; the FIFO pop is combinational from the load slot.
  always_comb begin
    can_load          = !tvalid || m_axis_c2h.tready;
    load_hdr          = (state == HEADER) && can_load;
    pop               = (state == STREAM) && can_load && !result_fifo_empty[col_sel];
    last_hs           = (state == DONE) && tvalid && m_axis_c2h.tready && tlast;
    result_fifo_rd_en = '0;
    if (pop) result_fifo_rd_en[col_sel] = 1'b1;
  end

  // Counters, column cursor, output beat register and completion pulse.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      for (int unsigned i = 0; i < COL_MAX_SIZE; i++) row_cnt[i] <= '0;
      total       <= '0;
      remaining   <= '0;
      col_sel     <= '0;
      tdata       <= '0;
      tvalid      <= 1'b0;
      tlast       <= 1'b0;
      gather_done <= 1'b0;
    end else begin
      gather_done <= last_hs;
      if ((state == IDLE) && start) begin
        for (int unsigned i = 0; i < COL_MAX_SIZE; i++) row_cnt[i] <= result_rows[16*i +: 16];
        total     <= start_total;
        remaining <= start_total;
        col_sel   <= start_col;
      end
      if (load_hdr) begin
        tdata  <= header;
        tvalid <= 1'b1;
        tlast  <= (total == '0);
      end else if (pop) begin
        tdata            <= result_fifo_dout[DATA_WIDTH*int'(col_sel) +: DATA_WIDTH];
        tvalid           <= 1'b1;
        tlast            <= (remaining == 32'd1);
        row_cnt[col_sel] <= row_cnt[col_sel] - 16'd1;
        remaining        <= remaining - 32'd1;
        if (row_cnt[col_sel] == 16'd1) col_sel <= next_col;
      end else if (can_load) begin
        tvalid <= 1'b0;
        tlast  <= 1'b0;
      end
    end
  end

  assign tkeep             = tvalid ? '1 : '0;
  assign m_axis_c2h.tdata  = tdata;
  assign m_axis_c2h.tvalid = tvalid;
  assign m_axis_c2h.tlast  = tlast;
  assign m_axis_c2h.tkeep  = tkeep;
endmodule

// File: tb/tb_c2h_gather.sv
// Self-checking bench for c2h_gather: FWFT FIFO models, stream monitor and a
// packet-level reference (header + per-column words in column order).
module tb_c2h_gather;
  localparam int DW = 128;
  localparam int NC = 4;

  logic              user_clk = 1'b0;
  logic              user_rst = 1'b1;
  logic              start = 1'b0;
  logic [16*NC-1:0]  result_rows = '0;
  logic [DW*NC-1:0]  result_fifo_dout;
  logic [NC-1:0]     result_fifo_empty;
  logic [NC-1:0]     result_fifo_rd_en;
  logic              gather_done;

  c2h_gather_if #(.DATA_WIDTH(DW), .BYTE_BIT_ENABLE(DW/8)) axis ();

  c2h_gather #(.DATA_WIDTH(DW), .BYTE_BIT_ENABLE(DW/8), .COL_MAX_SIZE(NC)) dut (
    .user_clk          (user_clk),
    .user_rst          (user_rst),
    .start             (start),
    .result_rows       (result_rows),
    .result_fifo_dout  (result_fifo_dout),
    .result_fifo_empty (result_fifo_empty),
    .result_fifo_rd_en (result_fifo_rd_en),
    .m_axis_c2h        (axis),
    .gather_done       (gather_done)
  );

  always #5 user_clk = ~user_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] fifo_q [NC][$];
  logic [DW-1:0] data_q [NC][$];
  logic [DW:0]   exp_q[$];
  logic [DW:0]   obs_q[$];
  int            hs_cyc[$];
  logic [NC-1:0] pend_pop = '0;
  int            pops [NC];
  int            bad_pop, stall_viol, stall_cycles, keep_viol;
  int            done_cnt, done_cyc, last_hs_cyc, start_cyc, first_valid_cyc;
  int            tready_mode = 0;
  int            stall_left = 0;
  bit            stall_done = 0;
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;

  always @(posedge user_clk) cyc++;

  // FWFT FIFO model: apply pops seen in the previous cycle, then present heads.
  always @(posedge user_clk) begin
    #1;
    for (int unsigned c = 0; c < NC; c++) begin
      if (pend_pop[c] && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
      result_fifo_empty[c] = (fifo_q[c].size() == 0);
      result_fifo_dout[DW*c +: DW] = (fifo_q[c].size() > 0) ? fifo_q[c][0] : '0;
    end
  end

  // Sink ready pattern: always-ready, or alternating with one long stall on beat 3.
  always @(posedge user_clk) begin
    #1;
    if (tready_mode == 0) axis.tready = 1'b1;
    else if (stall_left > 0) begin
      axis.tready = 1'b0;
      stall_left--;
    end else if (!stall_done && obs_q.size() == 2 && axis.tvalid) begin
      stall_done  = 1;
      stall_left  = 4;
      axis.tready = 1'b0;
    end else axis.tready = ~axis.tready;
  end

  // Monitor sampled mid-cycle: pops, rule violations, accepted beats, done pulse.
  always @(negedge user_clk) begin
    if (user_rst) begin
      pend_pop   = '0;
      prev_stall = 1'b0;
    end else begin
      pend_pop = result_fifo_rd_en;
      if ($countones(result_fifo_rd_en) > 1) bad_pop++;
      for (int unsigned c = 0; c < NC; c++)
        if (result_fifo_rd_en[c]) begin
          pops[c]++;
          if (result_fifo_empty[c]) bad_pop++;
        end
      if (axis.tkeep !== {(DW/8){axis.tvalid}}) keep_viol++;
      if (prev_stall && (axis.tvalid !== 1'b1 || {axis.tlast, axis.tdata} !== prev_beat)) stall_viol++;
      prev_stall = axis.tvalid && !axis.tready;
      if (prev_stall) stall_cycles++;
      prev_beat = {axis.tlast, axis.tdata};
      if (start && start_cyc < 0) start_cyc = cyc;
      if (axis.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (axis.tvalid && axis.tready) begin
        obs_q.push_back({axis.tlast, axis.tdata});
        hs_cyc.push_back(cyc);
        if (axis.tlast) last_hs_cyc = cyc;
      end
      if (gather_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    obs_q.delete();
    hs_cyc.delete();
    for (int unsigned c = 0; c < NC; c++) pops[c] = 0;
    bad_pop = 0; stall_viol = 0; stall_cycles = 0; keep_viol = 0;
    done_cnt = 0; done_cyc = -1; last_hs_cyc = -100;
    start_cyc = -1; first_valid_cyc = -1;
    stall_done = 0; stall_left = 0;
  endtask

  // Loads FIFOs with random words (two spare per column) and builds the expected packet.
  task automatic setup_packet(input int r0, input int r1, input int r2, input int r3,
                              input logic [NC-1:0] skip);
    int rows [NC];
    int total;
    logic [DW-1:0] w;
    rows  = '{r0, r1, r2, r3};
    total = 0;
    exp_q.delete();
    for (int unsigned c = 0; c < NC; c++) begin
      fifo_q[c].delete();
      data_q[c].delete();
      for (int k = 0; k < rows[c] + 2; k++) begin
        w = {$urandom, $urandom, $urandom, $urandom};
        data_q[c].push_back(w);
        if (!skip[c]) fifo_q[c].push_back(w);
      end
      total += rows[c];
      result_rows[16*c +: 16] = 16'(rows[c]);
    end
    exp_q.push_back({(total == 0), 16'(r3), 16'(r2), 16'(r1), 16'(r0), 32'(total), 32'h0000_C2A0});
    for (int unsigned c = 0; c < NC; c++)
      for (int k = 0; k < rows[c]; k++) exp_q.push_back({1'b0, data_q[c][k]});
    if (total > 0) exp_q[exp_q.size()-1][DW] = 1'b1;
    clear_stats();
  endtask

  task automatic pulse_start();
    @(posedge user_clk); #1 start = 1'b1;
    @(posedge user_clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge user_clk);
      if (done_cnt > 0) begin
        timed_out = 0;
        break;
      end
    end
    repeat (3) @(negedge user_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge user_clk);
    checks++; if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", axis.tvalid); end
    checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", axis.tlast); end
    checks++; if (axis.tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h want 0", axis.tdata); end
    checks++; if (axis.tkeep !== '0) begin errors++; $display("FAIL rst_tkeep got %h want 0", axis.tkeep); end
    checks++; if (result_fifo_rd_en !== '0) begin errors++; $display("FAIL rst_rd_en got %b want 0", result_fifo_rd_en); end
    checks++; if (gather_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", gather_done); end
    @(posedge user_clk); #2 user_rst = 1'b0;
    repeat (2) @(posedge user_clk);
  endtask

  task automatic test_basic();
    bit to;
    setup_packet(2, 1, 0, 3, '0);
    pulse_start();
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no gather_done want pulse"); end
    checks++; if (obs_q.size() != 7) begin errors++; $display("FAIL basic_beats got %0d want 7", obs_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0][127:32] !== {64'h0003_0000_0001_0002, 32'd6}) begin
        errors++; $display("FAIL basic_header got %h want 0003000000010002_00000006", obs_q[0][127:32]);
      end
    end
    checks++; if (pops[0] != 2 || pops[1] != 1 || pops[2] != 0 || pops[3] != 3) begin
      errors++; $display("FAIL basic_pops got %0d/%0d/%0d/%0d want 2/1/0/3", pops[0], pops[1], pops[2], pops[3]); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL basic_bad_pop got %0d want 0", bad_pop); end
    checks++; if (keep_viol != 0) begin errors++; $display("FAIL basic_tkeep got %0d violations want 0", keep_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", done_cnt); end
    checks++; if (done_cyc - last_hs_cyc != 1) begin errors++; $display("FAIL basic_done_delay got %0d want 1", done_cyc - last_hs_cyc); end
    checks++; if (first_valid_cyc - start_cyc != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", first_valid_cyc - start_cyc); end
  endtask

  task automatic test_zero_rows();
    bit to;
    setup_packet(0, 0, 0, 0, '0);
    pulse_start();
    wait_done(50, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout got no gather_done want pulse"); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL zero_beats got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL zero_header got %h want %h", obs_q[0], exp_q[0]); end
    end
    checks++; if (pops[0] + pops[1] + pops[2] + pops[3] != 0) begin
      errors++; $display("FAIL zero_pops got %0d want 0", pops[0] + pops[1] + pops[2] + pops[3]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_pressure();
    bit to;
    int n;
    tready_mode = 1;
    setup_packet(2, 1, 0, 3, '0);
    pulse_start();
    for (int i = 0; i < 100 && obs_q.size() < 3; i++) @(negedge user_clk);
    // Start while streaming must not relatch rows or spawn a second packet.
    @(posedge user_clk); #1 start = 1'b1; result_rows = {4{16'd5}};
    @(posedge user_clk); #1 start = 1'b0;
    wait_done(200, to);
    repeat (20) @(negedge user_clk);
    tready_mode = 0;
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got no gather_done want pulse"); end
    checks++; if (obs_q.size() != 7) begin errors++; $display("FAIL bp_beats got %0d want 7", obs_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n = pops[0] + pops[1] + pops[2] + pops[3];
    checks++; if (n != 6) begin errors++; $display("FAIL bp_pops got %0d want 6", n); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
    checks++; if (stall_cycles < 5) begin errors++; $display("FAIL bp_stalls got %0d want >=5", stall_cycles); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL bp_bad_pop got %0d want 0", bad_pop); end
  endtask

  task automatic test_underflow();
    bit to;
    int v_win, rd_win;
    setup_packet(2, 3, 1, 2, 4'b0010);
    pulse_start();
    for (int i = 0; i < 50 && pops[0] < 2; i++) @(negedge user_clk);
    repeat (3) @(negedge user_clk);
    v_win = 0; rd_win = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge user_clk);
      if (axis.tvalid) v_win++;
      if (result_fifo_rd_en[1]) rd_win++;
    end
    for (int k = 0; k < data_q[1].size(); k++) fifo_q[1].push_back(data_q[1][k]);
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL uf_timeout got no gather_done want pulse"); end
    checks++; if (v_win != 0) begin errors++; $display("FAIL uf_tvalid_low got %0d valid cycles want 0", v_win); end
    checks++; if (rd_win != 0) begin errors++; $display("FAIL uf_rd_en1 got %0d pops want 0", rd_win); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL uf_beats got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL uf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL uf_bad_pop got %0d want 0", bad_pop); end
    checks++; if (pops[1] != 3) begin errors++; $display("FAIL uf_pops1 got %0d want 3", pops[1]); end
  endtask

  task automatic test_reset_retrigger();
    bit to;
    int rd_in_rst;
    setup_packet(16, 16, 16, 16, '0);
    pulse_start();
    for (int i = 0; i < 100 && obs_q.size() < 8; i++) @(negedge user_clk);
    @(posedge user_clk); #3 user_rst = 1'b1;
    #1;
    checks++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || axis.tkeep !== '0) begin
      errors++; $display("FAIL rr_ctrl got v=%b l=%b k=%h want 0", axis.tvalid, axis.tlast, axis.tkeep); end
    checks++; if (axis.tdata !== '0) begin errors++; $display("FAIL rr_tdata got %h want 0", axis.tdata); end
    checks++; if (result_fifo_rd_en !== '0) begin errors++; $display("FAIL rr_rd_en got %b want 0", result_fifo_rd_en); end
    rd_in_rst = 0;
    repeat (3) begin
      @(negedge user_clk);
      if (result_fifo_rd_en !== '0) rd_in_rst++;
    end
    checks++; if (rd_in_rst != 0) begin errors++; $display("FAIL rr_pop_in_reset got %0d want 0", rd_in_rst); end
    @(posedge user_clk); #3 user_rst = 1'b0;
    repeat (3) @(posedge user_clk);
    setup_packet(1, 0, 0, 0, '0);
    pulse_start();
    wait_done(50, to);
    checks++; if (to) begin errors++; $display("FAIL rr_timeout got no gather_done want pulse"); end
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL rr_beats got %0d want 2", obs_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_throughput();
    bit to;
    setup_packet(16, 16, 16, 16, '0);
    pulse_start();
    wait_done(200, to);
    checks++; if (to) begin errors++; $display("FAIL tp_timeout got no gather_done want pulse"); end
    checks++; if (obs_q.size() != 65) begin errors++; $display("FAIL tp_beats got %0d want 65", obs_q.size()); end
    if (hs_cyc.size() == 65) begin
      checks++;
      if (hs_cyc[64] - hs_cyc[0] != 64) begin errors++; $display("FAIL tp_gapless got span %0d want 64", hs_cyc[64] - hs_cyc[0]); end
    end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0][63:32] !== 32'd64) begin errors++; $display("FAIL tp_total got %0d want 64", obs_q[0][63:32]); end
    end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (first_valid_cyc - start_cyc != 2) begin errors++; $display("FAIL tp_latency got %0d want 2", first_valid_cyc - start_cyc); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL tp_bad_pop got %0d want 0", bad_pop); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_zero_rows();
    test_back_pressure();
    test_underflow();
    test_reset_retrigger();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
